// File: rtl/fq_pkg.sv
// Shared types and constants for the instruction fetch queue between F and D.
package fq_pkg;

   localparam int unsigned FQ_DEPTH_DEFAULT = 4;
   localparam logic [31:0] FQ_RESET_PC      = 32'h0000_3000;
   localparam logic [31:0] FQ_NOP           = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// DEPTH x 64-bit entry storage: synchronous write, asynchronous read, no reset
// (entry validity is tracked by the occupancy count in fetch_queue).
module fq_ram
   import fq_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  fq_entry_t     wdata_i,
   input  logic [AW-1:0] raddr_i,
   output fq_entry_t     rdata_o
);

   fq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// In-order F->D instruction fetch queue with flush and full-stall.
// Optional same-cycle F->D bypass when empty: define FQ_BYPASS_EN.
module fetch_queue
   import fq_pkg::*;
#(
   parameter int unsigned DEPTH    = FQ_DEPTH_DEFAULT,
   parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
   input  logic                    FQ_clk_F_i,
   input  logic                    FQ_reset_F_i,
   input  logic [31:0]             FQ_pc_F_i,
   input  logic [31:0]             FQ_instr_F_i,
   input  logic                    FQ_valid_F_i,
   output logic                    FQ_full_F_o,
   output logic [$clog2(DEPTH):0]  FQ_count_F_o,
   input  logic                    FQ_stall_D_i,
   input  logic                    FQ_flush_i,
   output logic                    FQ_valid_D_o,
   output logic [31:0]             FQ_pc_D_o,
   output logic [31:0]             FQ_instr_D_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;

   logic      empty;
   logic      bypass;
   logic      push;
   logic      pop;
   fq_entry_t wr_entry;
   fq_entry_t rd_entry;

   assign empty    = (count_q == '0);
   assign wr_entry = '{pc: FQ_pc_F_i, instr: FQ_instr_F_i};

`ifdef FQ_BYPASS_EN
   assign bypass = empty && !FQ_flush_i && FQ_valid_F_i;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed pair that decode accepts is consumed directly and never stored.
   assign push = FQ_valid_F_i && !full_q && !FQ_flush_i && !(bypass && !FQ_stall_D_i);
   assign pop  = !empty && !FQ_stall_D_i && !FQ_flush_i;

   fq_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (FQ_clk_F_i),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rptr_q),
      .rdata_o (rd_entry)
   );

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (FQ_flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      full_d = (count_d == FULL_CNT);
   end

   always_ff @(posedge FQ_clk_F_i or posedge FQ_reset_F_i) begin
      if (FQ_reset_F_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   always_comb begin
      FQ_valid_D_o = 1'b0;
      FQ_pc_D_o    = RESET_PC;
      FQ_instr_D_o = FQ_NOP;
      if (!empty) begin
         FQ_valid_D_o = 1'b1;
         FQ_pc_D_o    = rd_entry.pc;
         FQ_instr_D_o = rd_entry.instr;
      end else if (bypass) begin
         FQ_valid_D_o = 1'b1;
         FQ_pc_D_o    = FQ_pc_F_i;
         FQ_instr_D_o = FQ_instr_F_i;
      end
   end

   assign FQ_full_F_o  = full_q;
   assign FQ_count_F_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected D-side pairs,
// a negedge monitor compares every accepted head entry in order.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_F = '0;
   logic [31:0] instr_F = '0;
   logic        valid_F = 1'b0;
   logic        full_F;
   logic [2:0]  count_F;
   logic        stall_D = 1'b1;
   logic        flush = 1'b0;
   logic        valid_D;
   logic [31:0] pc_D;
   logic [31:0] instr_D;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_3000)
   ) dut (
      .FQ_clk_F_i   (clk),
      .FQ_reset_F_i (rst),
      .FQ_pc_F_i    (pc_F),
      .FQ_instr_F_i (instr_F),
      .FQ_valid_F_i (valid_F),
      .FQ_full_F_o  (full_F),
      .FQ_count_F_o (count_F),
      .FQ_stall_D_i (stall_D),
      .FQ_flush_i   (flush),
      .FQ_valid_D_o (valid_D),
      .FQ_pc_D_o    (pc_D),
      .FQ_instr_D_o (instr_D)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_in(input logic [31:0] pc, input logic [31:0] ins, input bit acc);
      valid_F = 1'b1;
      pc_F    = pc;
      instr_F = ins;
      if (acc) exp_q.push_back({pc, ins});
      tick();
      valid_F = 1'b0;
   endtask

   // Monitor: every cycle decode accepts a valid head, it must match the next expected pair.
   always @(negedge clk) begin
      if (!rst && valid_D && !stall_D && !flush) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got %h expected none", {pc_D, instr_D});
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({pc_D, instr_D} !== e) begin
               n_bad++;
               $display("FAIL pop_entry: got %h expected %h", {pc_D, instr_D}, e);
            end
         end
      end
   end

   initial begin
      // Reset state
      #3;
      check("rst_valid", 64'(valid_D), 64'd0);
      check("rst_full",  64'(full_F),  64'd0);
      check("rst_count", 64'(count_F), 64'd0);
      check("rst_instr", 64'(instr_D), 64'h0);
      check("rst_pc",    64'(pc_D),    64'h3000);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Two pushes under stall, then in-order drain
      stall_D = 1'b1;
      push_in(32'h3000, 32'h2401_0001, 1'b1);
      push_in(32'h3004, 32'h2402_0002, 1'b1);
      check("t1_count", 64'(count_F), 64'd2);
      check("t1_head",  64'(pc_D),    64'h3000);
      stall_D = 1'b0;
      tick();
      tick();
      check("t1_empty_valid", 64'(valid_D), 64'd0);
      check("t1_empty_instr", 64'(instr_D), 64'h0);
      stall_D = 1'b1;

      // Fill, overflow drop, pop+push while full
      push_in(32'h3000, 32'h2400_3000, 1'b1);
      push_in(32'h3004, 32'h2400_3004, 1'b1);
      push_in(32'h3008, 32'h2400_3008, 1'b1);
      push_in(32'h300C, 32'h2400_300C, 1'b1);
      check("t2_full",  64'(full_F),  64'd1);
      check("t2_count", 64'(count_F), 64'd4);
      push_in(32'h3010, 32'h2400_3010, 1'b0);
      check("t2_drop_count", 64'(count_F), 64'd4);
      stall_D = 1'b0;
      push_in(32'h3014, 32'h2400_3014, 1'b0);
      stall_D = 1'b1;
      check("t2_popfull_count", 64'(count_F), 64'd3);
      check("t2_popfull_full",  64'(full_F),  64'd0);
      stall_D = 1'b0;
      repeat (3) tick();
      stall_D = 1'b1;
      check("t2_drained", 64'(count_F), 64'd0);

      // Steady state at count 2 across pointer wrap
      push_in(32'h3020, 32'h2400_3020, 1'b1);
      push_in(32'h3024, 32'h2400_3024, 1'b1);
      stall_D = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push_in(32'h3028 + 32'(4 * i), 32'h2500_0000 + 32'(i), 1'b1);
         check("t3_count_stable", 64'(count_F), 64'd2);
      end
      repeat (2) tick();
      stall_D = 1'b1;
      check("t3_drained", 64'(count_F), 64'd0);

      // Flush with count 3 and a concurrent push
      push_in(32'h3100, 32'h2400_3100, 1'b1);
      push_in(32'h3104, 32'h2400_3104, 1'b1);
      push_in(32'h3108, 32'h2400_3108, 1'b1);
      check("t4_pre_count", 64'(count_F), 64'd3);
      flush = 1'b1;
      push_in(32'h310C, 32'h2400_310C, 1'b0);
      flush = 1'b0;
      exp_q.delete();
      check("t4_count", 64'(count_F), 64'd0);
      check("t4_valid", 64'(valid_D), 64'd0);
      check("t4_pc",    64'(pc_D),    64'h3000);
      stall_D = 1'b0;
      tick();
      stall_D = 1'b1;
      check("t4_absent", 64'(count_F), 64'd0);

      // Asynchronous reset between edges
      push_in(32'h3200, 32'h2400_3200, 1'b1);
      push_in(32'h3204, 32'h2400_3204, 1'b1);
      check("t5_pre_count", 64'(count_F), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check("t5_count", 64'(count_F), 64'd0);
      check("t5_valid", 64'(valid_D), 64'd0);
      check("t5_full",  64'(full_F),  64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Empty queue, decode ready: bypass or one-cycle latency
      stall_D = 1'b0;
      valid_F = 1'b1;
      pc_F    = 32'h3000;
      instr_F = 32'h2401_0001;
      exp_q.push_back({32'h3000, 32'h2401_0001});
      #1;
`ifdef FQ_BYPASS_EN
      check("t6_byp_valid", 64'(valid_D), 64'd1);
      check("t6_byp_instr", 64'(instr_D), 64'h2401_0001);
      tick();
      valid_F = 1'b0;
      check("t6_byp_count", 64'(count_F), 64'd0);
`else
      check("t6_nobyp_valid", 64'(valid_D), 64'd0);
      tick();
      valid_F = 1'b0;
      check("t6_nobyp_count", 64'(count_F), 64'd1);
      check("t6_nobyp_instr", 64'(instr_D), 64'h2401_0001);
      tick();
      check("t6_nobyp_after", 64'(count_F), 64'd0);
`endif
      stall_D = 1'b1;
      tick();
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
